// File: rtl/rf_alu_sequencer_pkg.sv
// Shared types for the register-file ALU sequencer: ALU opcodes and controller states.
package rf_alu_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_AND  = 2'b10,
      OP_PASS = 2'b11
   } op_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/rf_alu_sequencer_if.sv
// Command handshake bundle between a command source (master) and the sequencer (slave).
interface rf_alu_sequencer_if #(
   parameter int A_WIDTH = 3
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [A_WIDTH-1:0] cmd_src0;
   logic [A_WIDTH-1:0] cmd_src1;
   logic [A_WIDTH-1:0] cmd_dst;

   modport master (
      output cmd_valid, cmd_op, cmd_src0, cmd_src1, cmd_dst,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_src0, cmd_src1, cmd_dst,
      output cmd_ready
   );
endinterface

// File: rtl/rf_alu_sequencer_alu.sv
// Combinational ALU shared by the writeback path and the operand bypass path.
module rf_alu_sequencer_alu
   import rf_alu_sequencer_pkg::*;
#(
   parameter int D_WIDTH = 8
) (
   input  op_e                op,
   input  logic [D_WIDTH-1:0] a,
   input  logic [D_WIDTH-1:0] b,
   output logic [D_WIDTH-1:0] result
);

   // Opcode decode; ADD/SUB wrap with no carry or borrow out.
   always_comb begin
      result = a;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_PASS: result = a;
         default: result = a;
      endcase
   end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Register-file ALU sequencer: clears the LUT RAM after reset, then runs 1-cycle ALU writebacks.
// Optional build macro RF_ALU_SEQUENCER_FWD_EN: bypass stage-2 result instead of stalling on RAW.
module rf_alu_sequencer
   import rf_alu_sequencer_pkg::*;
#(
   parameter int A_WIDTH = 3,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   rf_alu_sequencer_if.slave  cmd,
   output logic [A_WIDTH-1:0] ram_r0_add,
   output logic [A_WIDTH-1:0] ram_r1_add,
   input  logic [D_WIDTH-1:0] ram_r0_data,
   input  logic [D_WIDTH-1:0] ram_r1_data,
   output logic               ram_we,
   output logic [A_WIDTH-1:0] ram_w_add,
   output logic [D_WIDTH-1:0] ram_w_data,
   output logic               res_valid,
   output logic [A_WIDTH-1:0] res_dst,
   output logic [D_WIDTH-1:0] res_data,
   output logic               busy
);

   localparam logic [A_WIDTH-1:0] CLR_LAST = {A_WIDTH{1'b1}};

   state_e             state_r;
   logic [A_WIDTH-1:0] clr_cnt_r;
   logic               s2_valid_r;
   op_e                s2_op_r;
   logic [A_WIDTH-1:0] s2_dst_r;
   logic [D_WIDTH-1:0] s2_a_r;
   logic [D_WIDTH-1:0] s2_b_r;

   logic [D_WIDTH-1:0] s2_res_s;
   logic [D_WIDTH-1:0] opa_s;
   logic [D_WIDTH-1:0] opb_s;
   logic               stall_s;
   logic               accept_s;

   rf_alu_sequencer_alu #(.D_WIDTH(D_WIDTH)) u_alu (
      .op     (s2_op_r),
      .a      (s2_a_r),
      .b      (s2_b_r),
      .result (s2_res_s)
   );

`ifdef RF_ALU_SEQUENCER_FWD_EN
   assign stall_s = 1'b0;
   assign opa_s   = (s2_valid_r && (cmd.cmd_src0 == s2_dst_r)) ? s2_res_s : ram_r0_data;
   assign opb_s   = (s2_valid_r && (cmd.cmd_src1 == s2_dst_r)) ? s2_res_s : ram_r1_data;
`else
   // The in-flight write only lands at the end of this cycle, so a matching read would be stale.
   assign stall_s = s2_valid_r && ((cmd.cmd_src0 == s2_dst_r) || (cmd.cmd_src1 == s2_dst_r));
   assign opa_s   = ram_r0_data;
   assign opb_s   = ram_r1_data;
`endif

   assign cmd.cmd_ready = (state_r == ST_RUN) && !stall_s;
   assign accept_s      = cmd.cmd_valid && cmd.cmd_ready;
   assign ram_r0_add    = cmd.cmd_src0;
   assign ram_r1_add    = cmd.cmd_src1;

   assign busy       = (state_r == ST_CLEAR);
   assign ram_we     = (state_r == ST_CLEAR) || s2_valid_r;
   assign ram_w_add  = (state_r == ST_CLEAR) ? clr_cnt_r : s2_dst_r;
   assign ram_w_data = (state_r == ST_CLEAR) ? {D_WIDTH{1'b0}} : s2_res_s;
   assign res_valid  = s2_valid_r && (state_r == ST_RUN);
   assign res_dst    = s2_dst_r;
   assign res_data   = s2_res_s;

   // Controller FSM: RAM clear sweep, then command capture into the stage-2 registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_CLEAR;
         clr_cnt_r  <= {A_WIDTH{1'b0}};
         s2_valid_r <= 1'b0;
         s2_op_r    <= OP_ADD;
         s2_dst_r   <= {A_WIDTH{1'b0}};
         s2_a_r     <= {D_WIDTH{1'b0}};
         s2_b_r     <= {D_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_CLEAR: begin
               clr_cnt_r  <= clr_cnt_r + A_WIDTH'(1);
               s2_valid_r <= 1'b0;
               if (clr_cnt_r == CLR_LAST) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_CLEAR;
               end
            end
            ST_RUN: begin
               if (accept_s) begin
                  s2_valid_r <= 1'b1;
                  s2_op_r    <= op_e'(cmd.cmd_op);
                  s2_dst_r   <= cmd.cmd_dst;
                  s2_a_r     <= opa_s;
                  s2_b_r     <= opb_s;
               end else begin
                  s2_valid_r <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_CLEAR;
               clr_cnt_r  <= {A_WIDTH{1'b0}};
               s2_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed self-checking bench for rf_alu_sequencer with a behavioural 1W/2R LUT RAM alongside.
module tb_rf_alu_sequencer;

   localparam int AW = 3;
   localparam int DW = 8;

`ifdef RF_ALU_SEQUENCER_FWD_EN
   localparam int EXP_STALL = 0;
`else
   localparam int EXP_STALL = 1;
`endif

   logic          clk;
   logic          rst;
   logic [AW-1:0] ram_r0_add, ram_r1_add, ram_w_add, res_dst;
   logic [DW-1:0] ram_r0_data, ram_r1_data, ram_w_data, res_data;
   logic          ram_we, res_valid, busy;

   logic          pre_en;
   logic [AW-1:0] pre_add;
   logic [DW-1:0] pre_data;
   logic [DW-1:0] mem [0:7];
   logic [DW-1:0] ref_mem [0:7];

   int n_cmp;
   int n_err;

   rf_alu_sequencer_if #(.A_WIDTH(AW)) cmd_if ();

   rf_alu_sequencer #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd_if.slave),
      .ram_r0_add  (ram_r0_add),
      .ram_r1_add  (ram_r1_add),
      .ram_r0_data (ram_r0_data),
      .ram_r1_data (ram_r1_data),
      .ram_we      (ram_we),
      .ram_w_add   (ram_w_add),
      .ram_w_data  (ram_w_data),
      .res_valid   (res_valid),
      .res_dst     (res_dst),
      .res_data    (res_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model; the bench preload port takes priority over the sequencer's write port.
   always_ff @(posedge clk) begin
      if (pre_en) mem[pre_add] <= pre_data;
      else if (ram_we) mem[ram_w_add] <= ram_w_data;
   end
   assign ram_r0_data = mem[ram_r0_add];
   assign ram_r1_data = mem[ram_r1_add];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pre_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pre_en = 1'b1; pre_add = a; pre_data = d;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic drive(input logic [1:0] op, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                        input logic [AW-1:0] d);
      cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op;
      cmd_if.cmd_src0 = s0; cmd_if.cmd_src1 = s1; cmd_if.cmd_dst = d;
   endtask

   // Holds the command until accepted (bounded); returns in the cycle after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                        input logic [AW-1:0] d, output int stalls);
      bit acc;
      acc = 1'b0; stalls = 0;
      drive(op, s0, s1, d);
      while (!acc && stalls < 8) begin
         @(negedge clk);
         if (cmd_if.cmd_ready) acc = 1'b1;
         else stalls++;
         tick();
      end
      cmd_if.cmd_valid = 1'b0;
      check_eq("accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic run_one(input string tag, input logic [1:0] op, input logic [AW-1:0] s0,
                          input logic [AW-1:0] s1, input logic [AW-1:0] d, input logic [DW-1:0] exp);
      int st;
      issue(op, s0, s1, d, st);
      @(negedge clk);
      check_eq({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
      check_eq({tag, "_res_dst"}, {29'd0, res_dst}, {29'd0, d});
      check_eq({tag, "_res_data"}, {24'd0, res_data}, {24'd0, exp});
      tick();
      check_eq({tag, "_mem"}, {24'd0, mem[d]}, {24'd0, exp});
   endtask

   logic [1:0]    s_op [16];
   logic [AW-1:0] s_s0 [16];
   logic [AW-1:0] s_s1 [16];
   logic [AW-1:0] s_d  [16];
   logic [DW-1:0] s_r  [16];

   initial begin
      int st;
      int cnt;
      logic [AW-1:0] prev_d;
      n_cmp = 0; n_err = 0;
      rst = 1'b1; pre_en = 1'b0; pre_add = '0; pre_data = '0;
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'b00;
      cmd_if.cmd_src0 = '0; cmd_if.cmd_src1 = '0; cmd_if.cmd_dst = '0;

      // Fill RAM with garbage under reset so the clear sweep is observable.
      for (int i = 0; i < 8; i++) pre_wr(AW'(i), 8'h5A ^ 8'(i));
      tick();
      @(negedge clk);
      check_eq("rst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd1);
      check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check_eq("rst_res_data", {24'd0, res_data}, 32'd0);
      check_eq("rst_res_dst", {29'd0, res_dst}, 32'd0);
      check_eq("rst_ram_we", {31'd0, ram_we}, 32'd1);
      tick();
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq("clr_busy", {31'd0, busy}, 32'd1);
         check_eq("clr_we", {31'd0, ram_we}, 32'd1);
         check_eq("clr_add", {29'd0, ram_w_add}, i);
         check_eq("clr_data", {24'd0, ram_w_data}, 32'd0);
         check_eq("clr_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
         tick();
      end
      @(negedge clk);
      check_eq("run_busy", {31'd0, busy}, 32'd0);
      check_eq("run_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      for (int i = 0; i < 8; i++) check_eq("clr_mem", {24'd0, mem[i]}, 32'd0);
      tick();

      run_one("add00", 2'b00, 3'd0, 3'd0, 3'd2, 8'h00);
      run_one("add22", 2'b00, 3'd2, 3'd2, 3'd3, 8'h00);

      pre_wr(3'd1, 8'hF0);
      pre_wr(3'd2, 8'h20);
      run_one("add_wrap", 2'b00, 3'd1, 3'd2, 3'd4, 8'h10);
      run_one("sub", 2'b01, 3'd2, 3'd1, 3'd5, 8'h30);
      run_one("and", 2'b10, 3'd1, 3'd2, 3'd6, 8'h20);

      // Back-to-back read-after-write on dst 3.
      pre_wr(3'd1, 8'd5);
      pre_wr(3'd2, 8'd7);
      drive(2'b00, 3'd1, 3'd2, 3'd3);
      @(negedge clk);
      check_eq("haz_first_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
      tick();
      drive(2'b00, 3'd3, 3'd3, 3'd4);
      @(negedge clk);
      check_eq("haz_first_res", {24'd0, res_data}, 32'd12);
      cnt = 0;
      while (!cmd_if.cmd_ready && cnt < 4) begin
         cnt++;
         tick();
         @(negedge clk);
      end
      tick();
      cmd_if.cmd_valid = 1'b0;
      check_eq("haz_stall", cnt, EXP_STALL);
      tick();
      check_eq("haz_mem3", {24'd0, mem[3]}, 32'd12);
      check_eq("haz_mem4", {24'd0, mem[4]}, 32'd24);

      // Reset lands in the write cycle of PASS 1 -> 6.
      issue(2'b11, 3'd1, 3'd0, 3'd6, st);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_res_valid", {31'd0, res_valid}, 32'd1);
      check_eq("mid_res_dst", {29'd0, res_dst}, 32'd6);
      tick();
      rst = 1'b0;
      cnt = 0;
      @(negedge clk);
      check_eq("mid_clr_res_valid", {31'd0, res_valid}, 32'd0);
      while (busy && cnt < 20) begin
         cnt++;
         tick();
         @(negedge clk);
      end
      check_eq("mid_busy_cycles", cnt, 32'd8);
      check_eq("mid_mem6", {24'd0, mem[6]}, 32'd0);
      tick();

      // Random non-hazard stream with cmd_valid held high.
      for (int i = 0; i < 8; i++) begin
         ref_mem[i] = 8'(i * 37 + 3);
         pre_wr(AW'(i), 8'(i * 37 + 3));
      end
      prev_d = 3'd0;
      for (int i = 0; i < 16; i++) begin
         s_op[i] = 2'($urandom_range(0, 3));
         s_s0[i] = 3'($urandom_range(0, 7));
         s_s1[i] = 3'($urandom_range(0, 7));
         s_d[i]  = 3'($urandom_range(0, 7));
         if (i > 0 && s_s0[i] == prev_d) s_s0[i] = s_s0[i] + 3'd1;
         if (i > 0 && s_s1[i] == prev_d) s_s1[i] = s_s1[i] + 3'd1;
         s_r[i] = ref_alu(s_op[i], ref_mem[s_s0[i]], ref_mem[s_s1[i]]);
         ref_mem[s_d[i]] = s_r[i];
         prev_d = s_d[i];
      end
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) drive(s_op[i], s_s0[i], s_s1[i], s_d[i]);
         else cmd_if.cmd_valid = 1'b0;
         @(negedge clk);
         if (i > 0) begin
            check_eq("str_res_valid", {31'd0, res_valid}, 32'd1);
            check_eq("str_res_dst", {29'd0, res_dst}, {29'd0, s_d[i-1]});
            check_eq("str_res_data", {24'd0, res_data}, {24'd0, s_r[i-1]});
         end
         if (i < 16) check_eq("str_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
         tick();
      end
      @(negedge clk);
      check_eq("str_idle", {31'd0, res_valid}, 32'd0);
      for (int i = 0; i < 8; i++) check_eq("str_mem", {24'd0, mem[i]}, {24'd0, ref_mem[i]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
